// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and constants for the unified memory bus arbiter.
// Owner ids, FSM encoding and funct3 access formats.
package memory_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    FMT_BYTE   = 3'b000,
    FMT_HALF   = 3'b001,
    FMT_WORD   = 3'b010,
    FMT_BYTE_U = 3'b100,
    FMT_HALF_U = 3'b101
  } mem_format_t;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  localparam logic [2:0] FORMAT_WORD = FMT_WORD;

  function automatic logic pick_owner(
    input logic i_req,
    input logic d_req,
    input logic data_priority,
    input logic last_grant
  );
    logic owner;
    owner = OWNER_FETCH;
    if (i_req && d_req) begin
      owner = data_priority ? OWNER_DATA
                            : ~last_grant;
    end else if (d_req) begin
      owner = OWNER_DATA;
    end
    return owner;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_timeout.sv
// Free-running BUSY-cycle counter for the arbiter.
// expired is high in the last permitted cycle.
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates fetch and load/store ports onto one memory bus.
// One outstanding access; hung accesses may time out.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter bit          DATA_PRIORITY  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_ack,
  output logic [31:0] i_read_data,
  output logic        i_error,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  input  logic [2:0]  d_format,
  output logic        d_ack,
  output logic [31:0] d_read_data,
  output logic        d_error,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_format,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ack,
  output logic        grant_data
);

  arb_state_t  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  fmt_q, fmt_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_err_q, i_err_d;
  logic        d_err_q, d_err_d;
  logic        winner;
  logic        expired;

  if (TIMEOUT_CYCLES != 0) begin : g_timeout
    bus_timeout_counter #(
      .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (state_q != ST_BUSY),
      .enable (state_q == ST_BUSY),
      .expired(expired)
    );
  end else begin : g_no_timeout
    assign expired = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_FETCH;
      last_q    <= OWNER_DATA;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      fmt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      fmt_q     <= fmt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    fmt_d     = fmt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_err_d   = i_err_q;
    d_err_d   = d_err_q;
    winner    = OWNER_FETCH;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          winner  = pick_owner(i_req, d_req,
                               DATA_PRIORITY,
                               last_q);
          owner_d = winner;
          state_d = ST_BUSY;
          if (winner == OWNER_DATA) begin
            wr_d    = d_write;
            addr_d  = d_address;
            wdata_d = d_write_data;
            fmt_d   = d_format;
          end else begin
            wr_d    = 1'b0;
            addr_d  = i_address;
            wdata_d = '0;
            fmt_d   = FORMAT_WORD;
          end
        end
      end
      ST_BUSY: begin
        // A late ack in the expiry cycle still counts as success.
        if (mem_ack || expired) begin
          state_d = ST_RESP;
          if (owner_q == OWNER_DATA) begin
            d_rdata_d = mem_ack ? mem_read_data : '0;
            d_err_d   = ~mem_ack;
          end else begin
            i_rdata_d = mem_ack ? mem_read_data : '0;
            i_err_d   = ~mem_ack;
          end
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req        = (state_q == ST_BUSY);
  assign mem_write      = wr_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_format     = fmt_q;

  assign i_ack = (state_q == ST_RESP) &&
                 (owner_q == OWNER_FETCH);
  assign d_ack = (state_q == ST_RESP) &&
                 (owner_q == OWNER_DATA);

  assign grant_data = (state_q != ST_IDLE) &&
                      (owner_q == OWNER_DATA);

  assign i_read_data = i_rdata_q;
  assign d_read_data = d_rdata_q;
  assign i_error     = i_err_q;
  assign d_error     = d_err_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench: priority/timeout instance plus
// a round-robin instance without timeout.
module tb_memory_bus_arbiter;

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // instance A: DATA_PRIORITY=1, TIMEOUT_CYCLES=4
  logic        i_req = 0;
  logic [31:0] i_address = 0;
  logic        i_ack;
  logic [31:0] i_read_data;
  logic        i_error;
  logic        d_req = 0;
  logic        d_write = 0;
  logic [31:0] d_address = 0;
  logic [31:0] d_write_data = 0;
  logic [2:0]  d_format = 0;
  logic        d_ack;
  logic [31:0] d_read_data;
  logic        d_error;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_format;
  logic [31:0] mem_read_data = 0;
  logic        mem_ack = 0;
  logic        grant_data;

  // instance B: DATA_PRIORITY=0, TIMEOUT_CYCLES=0
  logic        i_req_b = 0;
  logic [31:0] i_address_b = 32'h100;
  logic        i_ack_b;
  logic [31:0] i_read_data_b;
  logic        i_error_b;
  logic        d_req_b = 0;
  logic        d_write_b = 0;
  logic [31:0] d_address_b = 32'h200;
  logic [31:0] d_write_data_b = 0;
  logic [2:0]  d_format_b = 3'b010;
  logic        d_ack_b;
  logic [31:0] d_read_data_b;
  logic        d_error_b;
  logic        mem_req_b;
  logic        mem_write_b;
  logic [31:0] mem_address_b;
  logic [31:0] mem_write_data_b;
  logic [2:0]  mem_format_b;
  logic [31:0] mem_read_data_b = 0;
  logic        mem_ack_b = 0;
  logic        grant_data_b;

  memory_bus_arbiter #(
    .DATA_PRIORITY (1'b1),
    .TIMEOUT_CYCLES(4)
  ) dut_a (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_address(i_address),
    .i_ack(i_ack), .i_read_data(i_read_data),
    .i_error(i_error),
    .d_req(d_req), .d_write(d_write),
    .d_address(d_address),
    .d_write_data(d_write_data),
    .d_format(d_format),
    .d_ack(d_ack), .d_read_data(d_read_data),
    .d_error(d_error),
    .mem_req(mem_req), .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_format(mem_format),
    .mem_read_data(mem_read_data),
    .mem_ack(mem_ack),
    .grant_data(grant_data)
  );

  memory_bus_arbiter #(
    .DATA_PRIORITY (1'b0),
    .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clock(clock), .reset(reset),
    .i_req(i_req_b), .i_address(i_address_b),
    .i_ack(i_ack_b), .i_read_data(i_read_data_b),
    .i_error(i_error_b),
    .d_req(d_req_b), .d_write(d_write_b),
    .d_address(d_address_b),
    .d_write_data(d_write_data_b),
    .d_format(d_format_b),
    .d_ack(d_ack_b), .d_read_data(d_read_data_b),
    .d_error(d_error_b),
    .mem_req(mem_req_b), .mem_write(mem_write_b),
    .mem_address(mem_address_b),
    .mem_write_data(mem_write_data_b),
    .mem_format(mem_format_b),
    .mem_read_data(mem_read_data_b),
    .mem_ack(mem_ack_b),
    .grant_data(grant_data_b)
  );

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t mon_a;
  exp_t mon_b;

  int          ack_at = 0;
  logic [31:0] resp_data = 0;
  int          busy_cnt = 0;
  int          last_busy_len = 0;
  bit          prev_req = 0;
  bit          prev_ack = 0;

  bit          cap_write[$];
  bit          cap_grant[$];
  logic [31:0] cap_addr[$];
  logic [31:0] cap_wdata[$];
  logic [2:0]  cap_fmt[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=ack required=no ack",
             name);
  endtask

  // monitor + memory model for instance A
  always @(negedge clock) begin
    if (i_ack || d_ack) begin
      check("ack_exclusive",
            32'(i_ack & d_ack), 32'd0);
      if (sb_a.size() == 0) begin
        unexpected("a_unexpected_ack");
      end else begin
        mon_a = sb_a.pop_front();
        check("ack_port", 32'(d_ack),
              32'(mon_a.port));
        check("read_data",
              mon_a.port ? d_read_data : i_read_data,
              mon_a.data);
        check("error",
              32'(mon_a.port ? d_error : i_error),
              32'(mon_a.err));
        check("ack_after_busy", 32'(prev_req), 32'd1);
        check("ack_after_mem_ack", 32'(prev_ack),
              32'(!mon_a.err));
      end
    end
    if (reset && mem_req) begin
      busy_cnt++;
      if (busy_cnt == 1) begin
        cap_write.push_back(mem_write);
        cap_grant.push_back(grant_data);
        cap_addr.push_back(mem_address);
        cap_wdata.push_back(mem_write_data);
        cap_fmt.push_back(mem_format);
      end
      mem_ack = (ack_at != 0) && (busy_cnt == ack_at);
    end else begin
      if (busy_cnt > 0) last_busy_len = busy_cnt;
      busy_cnt = 0;
      mem_ack = 1'b0;
    end
    mem_read_data = resp_data;
    prev_req = mem_req;
    prev_ack = mem_ack;
  end

  // monitor + zero-wait memory for instance B
  always @(negedge clock) begin
    if (i_ack_b || d_ack_b) begin
      if (sb_b.size() == 0) begin
        unexpected("b_unexpected_ack");
      end else begin
        mon_b = sb_b.pop_front();
        check("rr_owner", 32'(d_ack_b),
              32'(mon_b.port));
        check("rr_data",
              d_ack_b ? d_read_data_b : i_read_data_b,
              mon_b.data);
      end
    end
    mem_ack_b = mem_req_b;
    mem_read_data_b = mem_address_b;
  end

  task automatic fetch_req(input logic [31:0] addr);
    bit seen;
    seen = 0;
    i_req = 1;
    i_address = addr;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clock);
      if (i_ack) seen = 1;
    end
    i_req = 0;
    check("fetch_ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic data_req(input bit wr,
                          input logic [31:0] addr,
                          input logic [31:0] wdata,
                          input logic [2:0] fmt);
    bit seen;
    seen = 0;
    d_req = 1;
    d_write = wr;
    d_address = addr;
    d_write_data = wdata;
    d_format = fmt;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clock);
      if (d_ack) seen = 1;
    end
    d_req = 0;
    check("data_ack_seen", 32'(seen), 32'd1);
  endtask

  function automatic exp_t mk(input bit p,
                              input logic [31:0] d,
                              input bit e);
    exp_t r;
    r.port = p;
    r.data = d;
    r.err = e;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen;
    #1;
    check("rst_i_ack", 32'(i_ack), 0);
    check("rst_d_ack", 32'(d_ack), 0);
    check("rst_i_rdata", i_read_data, 0);
    check("rst_d_rdata", d_read_data, 0);
    check("rst_i_err", 32'(i_error), 0);
    check("rst_d_err", 32'(d_error), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_mem_fmt", 32'(mem_format), 0);
    check("rst_grant", 32'(grant_data), 0);
    @(negedge clock);
    reset = 1;
    @(negedge clock);

    // single fetch, ack in 2nd BUSY cycle
    ack_at = 2;
    resp_data = 32'h0000_0013;
    cap_write.delete(); cap_grant.delete();
    cap_addr.delete(); cap_wdata.delete();
    cap_fmt.delete();
    sb_a.push_back(mk(0, 32'h13, 0));
    fetch_req(32'h0040_0000);
    #1;
    check("t1_fmt", 32'(cap_fmt[0]), 32'h2);
    check("t1_write", 32'(cap_write[0]), 0);
    check("t1_grant", 32'(cap_grant[0]), 0);
    check("t1_addr", cap_addr[0], 32'h0040_0000);
    check("t1_busy_len", last_busy_len, 2);

    // contention with data priority
    ack_at = 1;
    resp_data = 32'h0000_0AAA;
    cap_write.delete(); cap_grant.delete();
    cap_addr.delete(); cap_wdata.delete();
    cap_fmt.delete();
    sb_a.push_back(mk(1, 32'hAAA, 0));
    sb_a.push_back(mk(0, 32'hAAA, 0));
    fork
      fetch_req(32'h0040_0004);
      data_req(1, 32'h1001_0000,
               32'hDEAD_BEEF, 3'b010);
    join
    #1;
    check("t2_d_write", 32'(cap_write[0]), 1);
    check("t2_d_grant", 32'(cap_grant[0]), 1);
    check("t2_d_addr", cap_addr[0], 32'h1001_0000);
    check("t2_d_wdata", cap_wdata[0], 32'hDEAD_BEEF);
    check("t2_d_fmt", 32'(cap_fmt[0]), 32'h2);
    check("t2_i_grant", 32'(cap_grant[1]), 0);
    check("t2_i_write", 32'(cap_write[1]), 0);
    check("t2_i_addr", cap_addr[1], 32'h0040_0004);
    check("t2_i_fmt", 32'(cap_fmt[1]), 32'h2);

    // timeout with no mem_ack
    ack_at = 0;
    resp_data = 32'h5555_5555;
    sb_a.push_back(mk(1, 32'h0, 1));
    data_req(0, 32'h1001_0004, 0, 3'b010);
    #1;
    check("t4_busy_len", last_busy_len, 4);

    // ack coincides with expiry
    ack_at = 4;
    resp_data = 32'h1234_5678;
    sb_a.push_back(mk(1, 32'h1234_5678, 0));
    data_req(0, 32'h1001_0008, 0, 3'b000);
    #1;
    check("t5_busy_len", last_busy_len, 4);

    // reset during BUSY
    ack_at = 0;
    d_req = 1;
    d_write = 0;
    d_address = 32'h1001_000C;
    d_format = 3'b010;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (mem_req) seen = 1;
    end
    check("t6_busy_seen", 32'(seen), 1);
    check("t6_grant_before", 32'(grant_data), 1);
    @(posedge clock);
    #2 reset = 0;
    #1;
    check("t6_mem_req", 32'(mem_req), 0);
    check("t6_i_ack", 32'(i_ack), 0);
    check("t6_d_ack", 32'(d_ack), 0);
    check("t6_grant", 32'(grant_data), 0);
    d_req = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    repeat (5) @(negedge clock);
    ack_at = 1;
    resp_data = 32'h0000_0077;
    sb_a.push_back(mk(0, 32'h77, 0));
    fetch_req(32'h0040_0008);

    // round-robin on instance B
    sb_b.push_back(mk(0, 32'h100, 0));
    sb_b.push_back(mk(1, 32'h200, 0));
    sb_b.push_back(mk(0, 32'h100, 0));
    sb_b.push_back(mk(1, 32'h200, 0));
    i_req_b = 1;
    d_req_b = 1;
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clock);
      if (i_ack_b || d_ack_b) n++;
    end
    i_req_b = 0;
    d_req_b = 0;
    check("rr_ack_count", n, 4);

    repeat (4) @(negedge clock);
    check("a_sb_empty", sb_a.size(), 0);
    check("b_sb_empty", sb_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares one unified single-port memory bus between the core's instruction-fetch port and its load/store data port.
- Serialises requests, tracks one outstanding access, routes the response back to the owner, and times out hung accesses.
- Sits between the datapath/control pair and the memory interfaces; it lets the core run against one shared memory instead of split text/data memories.

Parameters:
- DATA_PRIORITY, 1, 1 = data port always wins contention; 0 = round-robin between fetch and data.
- TIMEOUT_CYCLES, 0, BUSY cycles without mem_ack before an error response; 0 disables the timeout; max 65535.

Ports:
- clock  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- i_req  in  1  fetch request; held high with stable i_address until i_ack
- i_address  in  32  fetch address
- i_ack  out  1  one-cycle pulse: fetch complete
- i_read_data  out  32  fetched word, valid while i_ack=1
- i_error  out  1  valid with i_ack: 1 = timed out
- d_req  in  1  data request; held with stable qualifiers until d_ack
- d_write  in  1  1 = store, 0 = load
- d_address  in  32  data address
- d_write_data  in  32  store data
- d_format  in  3  funct3 access format (byte/half/word, signed/unsigned)
- d_ack  out  1  one-cycle pulse: data access complete
- d_read_data  out  32  load data, valid while d_ack=1
- d_error  out  1  valid with d_ack: 1 = timed out
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_write  out  1  registered write strobe qualifier
- mem_address  out  32  registered address
- mem_write_data  out  32  registered store data
- mem_format  out  3  registered format; fetch uses 3'b010 (word)
- mem_read_data  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only in BUSY
- grant_data  out  1  1 while the data port owns the bus (BUSY/RESP)

Behaviour:
- Reset (async, reset=0):
  - state IDLE, all outputs 0, timeout counter 0.
  - last_grant = data, so the first contested round-robin grant goes to fetch.
  - Reset mid-access abandons the access with no ack; mem_req drops immediately and the memory must tolerate this.
- FSM state IDLE:
  - No requests: stay in IDLE.
  - Otherwise choose the winner; mem_* fields are registered from the winner.
  - A fetch grant forces mem_write=0 and mem_format=3'b010.
  - Set mem_req=1, latch owner, clear the counter, go to BUSY.
- FSM state BUSY:
  - mem_req=1 and mem_* fields stay stable.
  - On mem_ack: register mem_read_data into the owner's read_data, error=0, mem_req=0, go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1: read_data=0, error=1, mem_req=0, go to RESP.
  - Else increment the counter.
  - mem_ack in the same cycle as expiry: the ack wins, error=0.
- FSM state RESP:
  - Pulse the owner's ack for exactly one cycle.
  - Update last_grant to the owner, go to IDLE.
  - read_data and error hold until the next RESP; they are only meaningful with ack.
- Arbitration:
  - DATA_PRIORITY=1: d_req beats i_req.
  - DATA_PRIORITY=0: on contention, grant the port that is not last_grant.
  - A single requester is always granted.
- Latency and throughput:
  - The request sampled in IDLE at cycle N gives mem_req at N+1.
  - mem_ack at cycle M gives the port ack at M+1.
  - Minimum is 2 cycles from request to ack, and one access per 3 cycles.
- Requester rules:
  - A requester must drop req, or present a new request, in the cycle after its ack.
  - req high in IDLE is always treated as a new request.
- Ignored inputs: mem_ack outside BUSY; requests arriving while BUSY/RESP wait in IDLE.
- Invariants:
  - i_ack and d_ack are never high together.
  - mem_req is high only in BUSY.
  - grant_data=1 only for data ownership.

Decomposition:
- Shared package:
  - state encoding (IDLE/BUSY/RESP)
  - owner id constants (OWNER_FETCH=0, OWNER_DATA=1)
  - FORMAT_WORD=3'b010, the same funct3 encodings as the data memory interface
- Sub-module bus_timeout_counter:
  - 16-bit counter with clear/enable, async active-low reset, and an expired output.
  - Tied to constant 0 when TIMEOUT_CYCLES=0.

Test Plan:
- Single fetch: i_req, i_address=0x0040_0000; mem_ack 1 cycle after mem_req with data 0x0000_0013. Required: mem_format=3'b010, mem_write=0; i_ack one cycle after mem_ack, i_read_data=0x13, i_error=0; d_ack stays 0.
- Simultaneous i_req/d_req with DATA_PRIORITY=1: store d_address=0x1001_0000, d_write_data=0xDEAD_BEEF, d_format=3'b010. Required: data served first, mem_write=1, grant_data=1; fetch served next.
- DATA_PRIORITY=0, both requesting continuously for 4 accesses after reset. Required grant order: fetch, data, fetch, data.
- TIMEOUT_CYCLES=4, d_req load, mem_ack never arrives. Required: mem_req high exactly 4 cycles; d_ack next cycle with d_error=1, d_read_data=0; FSM back in IDLE.
- TIMEOUT_CYCLES=4, mem_ack in the 4th BUSY cycle (the expiry cycle). Required: d_error=0, d_read_data=mem_read_data.
- reset to 0 during BUSY. Required: mem_req, i_ack, d_ack, grant_data all 0 immediately; no ack after release; next i_req served normally.
